vending_change_fsm: RTL and testbench
=====================================

Name: vending_change_fsm

Overview:
Parametrised successor to the fixed-price nickel/dime/quarter vending FSM.
- Price and coin values are parameters.
- Accumulates credit as an explicit binary count rather than one state per amount.
- Vends when credit reaches the price, then returns change one coin per cycle using dimes first, then nickels.
- Adds a cancel/refund path, rejection of malformed coin strobes, and busy/credit status.
- Sits between the coin-acceptor front end (which delivers synchronised one-cycle strobes) and the dispenser/coin-return actuators.

Parameters:
PRICE, 30, item price in cents; must be a multiple of N_VAL and >= N_VAL.
N_VAL, 5, value of the n coin in cents.
D_VAL, 10, value of the d coin in cents; must be a multiple of N_VAL.
Q_VAL, 25, value of the q coin in cents; must be a multiple of N_VAL.
CREDIT_W, 7, credit register width; must satisfy 2^CREDIT_W > PRICE + Q_VAL.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-high reset.
n  in  1  nickel strobe; one cycle high = one coin.
d  in  1  dime strobe; one cycle high = one coin.
q  in  1  quarter strobe; one cycle high = one coin.
cancel  in  1  refund request; one-cycle pulse.
y  out  1  vend pulse; high for exactly one cycle per item.
chg_d  out  1  dispense one D_VAL coin this cycle.
chg_n  out  1  dispense one N_VAL coin this cycle.
coin_rej  out  1  registered one-cycle pulse: the coin(s) sampled on the previous edge were rejected.
busy  out  1  high in VEND and CHANGE.
credit  out  CREDIT_W  current credit in cents (registered).

Behaviour:
Reset:
- Async reset forces state IDLE, credit 0 and coin_rej 0, so y, chg_d, chg_n and busy read 0.
- Reset mid-vend or mid-change abandons that operation; any undispensed change is lost.

State outputs:
- y, chg_d, chg_n and busy are decoded only from registered state and credit. No combinational input-to-output path.

Coin strobe validity:
- Valid coin: exactly one of n/d/q high at a sampling edge.
- Two or more high: invalid. Credit is unchanged and coin_rej = 1 the next cycle.
- A strobe held for k cycles counts as k coins.

States:
- IDLE: credit == 0.
- ACCUM: 0 < credit < PRICE.
- VEND: one cycle only.
- CHANGE: dispensing change or refund.

IDLE/ACCUM transitions:
- cancel high in ACCUM: has priority over any coin. A coin in the same cycle is rejected (coin_rej). Next state CHANGE with credit unchanged (full refund).
- cancel in IDLE: ignored (a coin in the same cycle is processed normally).
- Valid coin of value v: credit <= credit + v.
  - If credit + v >= PRICE, next state VEND.
  - Otherwise, next state ACCUM.
- No coin and no cancel: hold.

VEND:
- y = 1 for the whole cycle.
- On the next edge, credit <= credit - PRICE.
- Next state CHANGE if the result is nonzero, otherwise IDLE.
- Latency: y is high in the cycle immediately after the edge that sampled the completing coin.

CHANGE (one coin per cycle):
- If credit >= D_VAL: chg_d = 1, and the next edge subtracts D_VAL.
- Otherwise: chg_n = 1, and the next edge subtracts N_VAL.
- chg_d and chg_n are never high together.
- When credit reaches 0, next state IDLE.
- The multiple-of-N_VAL constraints guarantee credit lands exactly on 0; there is no underflow.

VEND/CHANGE input handling:
- Any n/d/q high (valid or not) gives coin_rej the next cycle; credit is not affected.
- cancel is ignored.

Invariants:
- Maximum credit is PRICE - N_VAL + Q_VAL. Addition never overflows given the CREDIT_W rule.
- credit is never negative and never exceeds that maximum.

Test Plan:
- Defaults: d, then q on consecutive edges -> credit 10 then 35; y=1 one cycle; then credit 5, chg_n=1 one cycle; back to IDLE with credit 0 and busy 0.
- Six n pulses -> credit steps 5..30; y on the cycle after the sixth edge; no chg pulses; IDLE.
- Overpay to 50 (q, q) -> y, then credit 20 -> chg_d, chg_d on two cycles -> IDLE; total change dispensed = 20.
- d, n, then cancel -> CHANGE with credit 15 -> chg_d then chg_n -> IDLE; y never asserted.
- n and d high together in IDLE -> coin_rej=1 next cycle, credit stays 0. q strobe during CHANGE -> coin_rej, change sequence unaffected.
- Assert reset asynchronously (between clock edges) during CHANGE with credit 20 -> all outputs 0 and credit 0 immediately; after release, q then d -> credit 25 then 35, y. Repeat with PRICE=50, N_VAL=5, D_VAL=10, Q_VAL=25, CREDIT_W=7: q, q -> y, no change.

Source files
------------

// File: rtl/vending_change_fsm.sv
// Parametrised vending controller: binary credit accumulation, single-cycle vend,
// then change (or a cancel refund) returned one coin per cycle, dimes before nickels.
module vending_change_fsm #(
    parameter int PRICE    = 30,
    parameter int N_VAL    = 5,
    parameter int D_VAL    = 10,
    parameter int Q_VAL    = 25,
    parameter int CREDIT_W = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                n,
    input  logic                d,
    input  logic                q,
    input  logic                cancel,
    output logic                y,
    output logic                chg_d,
    output logic                chg_n,
    output logic                coin_rej,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        VEND,
        CHANGE
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] N_C     = CREDIT_W'(N_VAL);
    localparam logic [CREDIT_W-1:0] D_C     = CREDIT_W'(D_VAL);
    localparam logic [CREDIT_W-1:0] Q_C     = CREDIT_W'(Q_VAL);

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  coin_rej_q, coin_rej_d;

    logic                  any_coin;
    logic                  multi_coin;
    logic                  valid_coin;
    logic [CREDIT_W-1:0]   coin_val;
    logic [CREDIT_W-1:0]   sum;
    logic [CREDIT_W-1:0]   after_vend;
    logic [CREDIT_W-1:0]   after_chg;

    assign any_coin   = n | d | q;
    assign multi_coin = (n & d) | (n & q) | (d & q);
    assign valid_coin = any_coin & ~multi_coin;
    assign coin_val   = n ? N_C : (d ? D_C : Q_C);
    assign sum        = credit_q + coin_val;
    assign after_vend = credit_q - PRICE_C;
    assign after_chg  = (credit_q >= D_C) ? (credit_q - D_C) : (credit_q - N_C);

    // NOTE: every sequential state update uses <= so all registers see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            coin_rej_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            coin_rej_q <= coin_rej_d;
        end
    end

    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        coin_rej_d = 1'b0;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (state_q == ACCUM && cancel) begin
                    state_d    = CHANGE;
                    coin_rej_d = any_coin;
                end else if (valid_coin) begin
                    credit_d = sum;
                    state_d  = (sum >= PRICE_C) ? VEND : ACCUM;
                end else if (multi_coin) begin
                    coin_rej_d = 1'b1;
                end
            end
            VEND: begin
                credit_d   = after_vend;
                state_d    = (after_vend != '0) ? CHANGE : IDLE;
                coin_rej_d = any_coin;
            end
            CHANGE: begin
                credit_d   = after_chg;
                state_d    = (after_chg != '0) ? CHANGE : IDLE;
                coin_rej_d = any_coin;
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    // Outputs are pure decodes of registered state and credit.
    assign y        = (state_q == VEND);
    assign busy     = (state_q == VEND) || (state_q == CHANGE);
    assign chg_d    = (state_q == CHANGE) && (credit_q >= D_C);
    assign chg_n    = (state_q == CHANGE) && (credit_q < D_C);
    assign coin_rej = coin_rej_q;
    assign credit   = credit_q;

endmodule

// File: tb/tb_vending_change_fsm.sv
// Directed bench for vending_change_fsm: default pricing plus a PRICE=50 instance.
module tb_vending_change_fsm;

    logic       clk;
    logic       reset;
    logic       n, d, q, cancel;
    logic       y, chg_d, chg_n, coin_rej, busy;
    logic [6:0] credit;

    logic       n2, d2, q2, cancel2;
    logic       y2, chg_d2, chg_n2, coin_rej2, busy2;
    logic [6:0] credit2;

    int checks = 0;
    int errors = 0;

    vending_change_fsm dut (
        .clk(clk), .reset(reset), .n(n), .d(d), .q(q), .cancel(cancel),
        .y(y), .chg_d(chg_d), .chg_n(chg_n), .coin_rej(coin_rej),
        .busy(busy), .credit(credit)
    );

    vending_change_fsm #(
        .PRICE(50), .N_VAL(5), .D_VAL(10), .Q_VAL(25), .CREDIT_W(7)
    ) dut50 (
        .clk(clk), .reset(reset), .n(n2), .d(d2), .q(q2), .cancel(cancel2),
        .y(y2), .chg_d(chg_d2), .chg_n(chg_n2), .coin_rej(coin_rej2),
        .busy(busy2), .credit(credit2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic vn, input logic vd, input logic vq, input logic vc);
        n = vn; d = vd; q = vq; cancel = vc;
    endtask

    task automatic expect_out(input string tag, input int ey, input int ecd, input int ecn,
                              input int erej, input int ebusy, input int ecred);
        check({tag, ".y"},        32'(y),        32'(ey));
        check({tag, ".chg_d"},    32'(chg_d),    32'(ecd));
        check({tag, ".chg_n"},    32'(chg_n),    32'(ecn));
        check({tag, ".coin_rej"}, 32'(coin_rej), 32'(erej));
        check({tag, ".busy"},     32'(busy),     32'(ebusy));
        check({tag, ".credit"},   32'(credit),   32'(ecred));
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0);
        n2 = 0; d2 = 0; q2 = 0; cancel2 = 0;
        #22 reset = 1'b0;
        tick();
        expect_out("reset", 0, 0, 0, 0, 0, 0);

        // d then q: 10, 35, vend, 5 change as a nickel
        set_in(0, 1, 0, 0); tick(); expect_out("dq.d", 0, 0, 0, 0, 0, 10);
        set_in(0, 0, 1, 0); tick(); expect_out("dq.vend", 1, 0, 0, 0, 1, 35);
        set_in(0, 0, 0, 0); tick(); expect_out("dq.chg", 0, 0, 1, 0, 1, 5);
        tick();                     expect_out("dq.idle", 0, 0, 0, 0, 0, 0);

        // six nickels, exact price
        for (int i = 1; i <= 6; i++) begin
            set_in(1, 0, 0, 0); tick();
            check("n6.credit", 32'(credit), 32'(5 * i));
            check("n6.y", 32'(y), (i == 6) ? 32'd1 : 32'd0);
            check("n6.chg", 32'({chg_d, chg_n}), 32'd0);
        end
        set_in(0, 0, 0, 0); tick(); expect_out("n6.idle", 0, 0, 0, 0, 0, 0);

        // overpay 50: two dimes of change
        set_in(0, 0, 1, 0); tick(); expect_out("qq.q1", 0, 0, 0, 0, 0, 25);
        set_in(0, 0, 1, 0); tick(); expect_out("qq.vend", 1, 0, 0, 0, 1, 50);
        set_in(0, 0, 0, 0); tick(); expect_out("qq.chg1", 0, 1, 0, 0, 1, 20);
        tick();                     expect_out("qq.chg2", 0, 1, 0, 0, 1, 10);
        tick();                     expect_out("qq.idle", 0, 0, 0, 0, 0, 0);

        // d, n, cancel: refund 15 as dime + nickel
        set_in(0, 1, 0, 0); tick(); expect_out("cx.d", 0, 0, 0, 0, 0, 10);
        set_in(1, 0, 0, 0); tick(); expect_out("cx.n", 0, 0, 0, 0, 0, 15);
        set_in(0, 0, 0, 1); tick(); expect_out("cx.chg1", 0, 1, 0, 0, 1, 15);
        set_in(0, 0, 0, 0); tick(); expect_out("cx.chg2", 0, 0, 1, 0, 1, 5);
        tick();                     expect_out("cx.idle", 0, 0, 0, 0, 0, 0);

        // malformed strobe in IDLE
        set_in(1, 1, 0, 0); tick(); expect_out("rej.nd", 0, 0, 0, 1, 0, 0);
        set_in(0, 0, 0, 0); tick(); expect_out("rej.clr", 0, 0, 0, 0, 0, 0);

        // cancel in IDLE ignored, coin accepted; cancel+coin in ACCUM rejects coin
        set_in(1, 0, 0, 1); tick(); expect_out("ci.idle", 0, 0, 0, 0, 0, 5);
        set_in(0, 1, 0, 1); tick(); expect_out("ca.rej", 0, 0, 1, 1, 1, 5);
        set_in(0, 0, 0, 0); tick(); expect_out("ca.idle", 0, 0, 0, 0, 0, 0);

        // quarter during CHANGE rejected, sequence unaffected
        set_in(0, 1, 0, 0); tick();
        set_in(1, 0, 0, 0); tick();
        set_in(0, 0, 0, 1); tick(); expect_out("qc.chg1", 0, 1, 0, 0, 1, 15);
        set_in(0, 0, 1, 0); tick(); expect_out("qc.chg2", 0, 0, 1, 1, 1, 5);
        set_in(0, 0, 0, 0); tick(); expect_out("qc.idle", 0, 0, 0, 0, 0, 0);

        // async reset mid-change
        set_in(0, 0, 1, 0); tick();
        tick();                     expect_out("ar.vend", 1, 0, 0, 0, 1, 50);
        set_in(0, 0, 0, 0); tick(); expect_out("ar.chg", 0, 1, 0, 0, 1, 20);
        #3 reset = 1'b1;
        #1 expect_out("ar.rst", 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        tick();                     expect_out("ar.post", 0, 0, 0, 0, 0, 0);
        set_in(0, 0, 1, 0); tick(); expect_out("ar.q", 0, 0, 0, 0, 0, 25);
        set_in(0, 1, 0, 0); tick(); expect_out("ar.vend2", 1, 0, 0, 0, 1, 35);
        set_in(0, 0, 0, 0); tick(); expect_out("ar.chg2", 0, 0, 1, 0, 1, 5);
        tick();                     expect_out("ar.idle", 0, 0, 0, 0, 0, 0);

        // PRICE=50 instance: q, q -> exact vend, no change
        check("p50.credit0", 32'(credit2), 32'd0);
        q2 = 1; tick();
        check("p50.q1.credit", 32'(credit2), 32'd25);
        check("p50.q1.y", 32'(y2), 32'd0);
        tick();
        check("p50.vend.y", 32'(y2), 32'd1);
        check("p50.vend.credit", 32'(credit2), 32'd50);
        q2 = 0; tick();
        check("p50.idle.credit", 32'(credit2), 32'd0);
        check("p50.idle.busy", 32'(busy2), 32'd0);
        check("p50.idle.chg", 32'({chg_d2, chg_n2}), 32'd0);
        check("p50.idle.y", 32'(y2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
